// File: rtl/ex_issue_stage_pkg.sv
// Shared ALU operation codes and instruction encodings for the issue stage and the ALU.
package ex_issue_stage_pkg;

  typedef enum logic [3:0] {
    ALU_NOP = 4'b0000,
    ALU_ADD = 4'b0001,
    ALU_SUB = 4'b0010,
    ALU_AND = 4'b0011,
    ALU_OR  = 4'b0100,
    ALU_XOR = 4'b0101
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

endpackage

// File: rtl/ex_issue_stage_if.sv
// Issue-stage bus: decoded instruction in, registered ALU payload out.
interface ex_issue_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_opcode;
  logic [5:0]    in_funct;
  logic [RW-1:0] in_rs_idx;
  logic [RW-1:0] in_rt_idx;
  logic [RW-1:0] in_rd_idx;
  logic [DW-1:0] in_rs_val;
  logic [DW-1:0] in_rt_val;
  logic [15:0]   in_imm;
  logic [3:0]    in_shamt;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [3:0]    ex_aluop;
  logic [3:0]    ex_shamt;
  logic          ex_cn;
  logic [RW-1:0] ex_wr_idx;
  logic          ex_wr_en;
  logic          ex_illegal;

  modport slave (
    input  in_valid, in_opcode, in_funct, in_rs_idx, in_rt_idx, in_rd_idx,
           in_rs_val, in_rt_val, in_imm, in_shamt, out_ready,
    output in_ready, out_valid, ex_a, ex_b, ex_aluop, ex_shamt, ex_cn,
           ex_wr_idx, ex_wr_en, ex_illegal
  );

  modport master (
    output in_valid, in_opcode, in_funct, in_rs_idx, in_rt_idx, in_rd_idx,
           in_rs_val, in_rt_val, in_imm, in_shamt, out_ready,
    input  in_ready, out_valid, ex_a, ex_b, ex_aluop, ex_shamt, ex_cn,
           ex_wr_idx, ex_wr_en, ex_illegal
  );
endinterface

// File: rtl/ex_issue_stage_alu_op_decode.sv
// Combinational opcode/funct decode into ALU control, operand-b source and destination select.
module alu_op_decode
  import ex_issue_stage_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] aluop,
  output logic       cn,
  output logic       use_imm,
  output logic       sext,
  output logic       wr_rd,
  output logic       illegal
);

  always_comb begin
    aluop   = ALU_NOP;
    cn      = 1'b0;
    use_imm = 1'b0;
    sext    = 1'b0;
    wr_rd   = 1'b0;
    illegal = 1'b1;
    if (opcode == OP_RTYPE) begin
      wr_rd = 1'b1;
      unique case (funct)
        FN_ADD:  begin aluop = ALU_ADD; illegal = 1'b0; end
        FN_SUB:  begin aluop = ALU_SUB; cn = 1'b1; illegal = 1'b0; end
        FN_AND:  begin aluop = ALU_AND; illegal = 1'b0; end
        FN_OR:   begin aluop = ALU_OR;  illegal = 1'b0; end
        FN_XOR:  begin aluop = ALU_XOR; illegal = 1'b0; end
        default: wr_rd = 1'b1;
      endcase
    end else begin
      unique case (opcode)
        OP_ADDI: begin aluop = ALU_ADD; use_imm = 1'b1; sext = 1'b1; illegal = 1'b0; end
        OP_ANDI: begin aluop = ALU_AND; use_imm = 1'b1; illegal = 1'b0; end
        OP_ORI:  begin aluop = ALU_OR;  use_imm = 1'b1; illegal = 1'b0; end
        OP_XORI: begin aluop = ALU_XOR; use_imm = 1'b1; illegal = 1'b0; end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX register stage feeding the execute ALU, with valid/ready handshake and flush.
// Build option: EX_ISSUE_FORWARDING_EN enables EX/MEM and MEM/WB operand bypass at capture.
module ex_issue_stage
  import ex_issue_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          fwd1_en,
  input  logic [RW-1:0] fwd1_idx,
  input  logic [DW-1:0] fwd1_val,
  input  logic          fwd2_en,
  input  logic [RW-1:0] fwd2_idx,
  input  logic [DW-1:0] fwd2_val,
  ex_issue_stage_if.slave bus
);

  logic [3:0]    dec_aluop;
  logic          dec_cn;
  logic          dec_use_imm;
  logic          dec_sext;
  logic          dec_wr_rd;
  logic          dec_illegal;
  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_rt;
  logic [DW-1:0] imm_ext;
  logic [RW-1:0] wr_idx_nxt;
  logic          wr_en_nxt;
  logic          capture;

  alu_op_decode u_dec (
    .opcode  (bus.in_opcode),
    .funct   (bus.in_funct),
    .aluop   (dec_aluop),
    .cn      (dec_cn),
    .use_imm (dec_use_imm),
    .sext    (dec_sext),
    .wr_rd   (dec_wr_rd),
    .illegal (dec_illegal)
  );

`ifdef EX_ISSUE_FORWARDING_EN
  // fwd1 (younger result) wins over fwd2; register 0 is never bypassed
  always_comb begin
    opnd_a = bus.in_rs_val;
    if (fwd1_en && fwd1_idx == bus.in_rs_idx && bus.in_rs_idx != '0)
      opnd_a = fwd1_val;
    else if (fwd2_en && fwd2_idx == bus.in_rs_idx && bus.in_rs_idx != '0)
      opnd_a = fwd2_val;

    opnd_rt = bus.in_rt_val;
    if (fwd1_en && fwd1_idx == bus.in_rt_idx && bus.in_rt_idx != '0)
      opnd_rt = fwd1_val;
    else if (fwd2_en && fwd2_idx == bus.in_rt_idx && bus.in_rt_idx != '0)
      opnd_rt = fwd2_val;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd1_en, fwd1_idx, fwd1_val, fwd2_en, fwd2_idx, fwd2_val};
  assign opnd_a  = bus.in_rs_val;
  assign opnd_rt = bus.in_rt_val;
`endif

  assign imm_ext    = dec_sext ? {{(DW-16){bus.in_imm[15]}}, bus.in_imm}
                               : {{(DW-16){1'b0}}, bus.in_imm};
  assign wr_idx_nxt = dec_wr_rd ? bus.in_rd_idx : bus.in_rt_idx;
  assign wr_en_nxt  = !dec_illegal && (wr_idx_nxt != '0);

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.ex_a       <= '0;
      bus.ex_b       <= '0;
      bus.ex_aluop   <= '0;
      bus.ex_shamt   <= '0;
      bus.ex_cn      <= 1'b0;
      bus.ex_wr_idx  <= '0;
      bus.ex_wr_en   <= 1'b0;
      bus.ex_illegal <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (capture) begin
      bus.out_valid  <= 1'b1;
      bus.ex_a       <= opnd_a;
      bus.ex_b       <= dec_use_imm ? imm_ext : opnd_rt;
      bus.ex_aluop   <= dec_aluop;
      bus.ex_shamt   <= bus.in_shamt;
      bus.ex_cn      <= dec_cn;
      bus.ex_wr_idx  <= wr_idx_nxt;
      bus.ex_wr_en   <= wr_en_nxt;
      bus.ex_illegal <= dec_illegal;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the execute ALU.
- Decodes opcode/funct into the ALU's 4-bit operation code.
- Selects and extends operands, and registers everything into the ALU input register.
- Uses a valid/ready handshake and supports flush; bypass forwarding is optional.

Parameters:
DW, 32, datapath width (ALU operand width)
RW, 5, register index width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  decoded instruction available
in_ready  out  1  stage can accept this cycle
in_opcode  in  6  instruction opcode
in_funct  in  6  R-type funct
in_rs_idx  in  RW  source register 1 index
in_rt_idx  in  RW  source register 2 index
in_rd_idx  in  RW  R-type destination index
in_rs_val  in  DW  register file read value for rs
in_rt_val  in  DW  register file read value for rt
in_imm  in  16  immediate field
in_shamt  in  4  shift amount
flush  in  1  kill stage contents (branch redirect)
fwd1_en / fwd1_idx / fwd1_val  in  1/RW/DW  EX/MEM bypass source
fwd2_en / fwd2_idx / fwd2_val  in  1/RW/DW  MEM/WB bypass source
out_valid  out  1  registered payload valid
out_ready  in  1  ALU/downstream accepts
ex_a  out  DW  ALU operand a
ex_b  out  DW  ALU operand b
ex_aluop  out  4  ALU operation code
ex_shamt  out  4  shift amount to ALU
ex_cn  out  1  carry-in: 1 for sub, else 0
ex_wr_idx  out  RW  writeback destination
ex_wr_en  out  1  writeback enable
ex_illegal  out  1  undecodable instruction flag

Behaviour:
Handshake and register stage:
- in_ready = !out_valid || out_ready.
- Capture occurs when in_valid && in_ready && !flush.
- out_valid is set on capture and cleared when out_valid && out_ready with no new capture.
- Accept and drain in the same cycle is allowed and gives back-to-back throughput of 1 per cycle.
- While out_valid && !out_ready, all ex_* outputs are held stable.
- Latency: 1 cycle from accepted input to out_valid.

Flush:
- On the next edge, out_valid=0 and no capture occurs, even if in_valid=1.
- Flush has priority over capture and over hold.

Reset:
- On rst at the edge, out_valid=0 and all ex_* outputs are 0.
- This applies even mid-transfer and discards any held payload.

Decode:
- R-type (opcode 000000), wr_idx=rd, b=rt operand:
  - funct 100000 add -> 0001
  - funct 100010 sub -> 0010, cn=1
  - funct 100100 and -> 0011
  - funct 100101 or -> 0100
  - funct 100110 xor -> 0101
- I-type, wr_idx=rt:
  - 001000 addi -> 0001, sign-extended imm
  - 001100 andi -> 0011, zero-extended imm
  - 001101 ori -> 0100, zero-extended imm
  - 001110 xori -> 0101, zero-extended imm
- Anything else: aluop=0000, wr_en=0, illegal=1, a/b still captured.
- wr_en is forced to 0 when wr_idx==0.
- ex_shamt = in_shamt, registered with the payload.

Optional Feature:
Macro: EX_ISSUE_FORWARDING_EN
- Defined:
  - Each rs/rt operand takes fwd1_val if fwd1_en && fwd1_idx==src && src!=0.
  - Otherwise it takes fwd2_val under the same rule.
  - Otherwise it takes the register-file value.
  - fwd1 has priority over fwd2.
  - Forwarding is sampled only at capture; held payload is not refreshed.
- Undefined: fwd* ports exist but are ignored, and operands come directly from in_rs_val/in_rt_val.

Decomposition:
- Shared package: ALU opcode constants (ALU_ADD=0001, ALU_SUB=0010, ALU_AND=0011, ALU_OR=0100, ALU_XOR=0101, ALU_NOP=0000) and opcode/funct constants.
- The ALU reuses the same package.
- One combinational sub-module, alu_op_decode: opcode/funct in; aluop, cn, imm-select, sign/zero-ext, wr_idx-select and illegal out.

Test Plan:
- Operand selection:
  - R add, rs_val=5, rt_val=7, out_ready=1 -> next cycle out_valid=1, ex_a=5, ex_b=7, aluop=0001, cn=0.
  - addi, imm=16'hFFFF -> ex_b=32'hFFFFFFFF.
  - ori, imm=16'hFFFF -> ex_b=32'h0000FFFF, wr_idx=rt.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, ex_* unchanged; out_ready=1 -> drain and accept the next instruction in the same cycle.
- Flush and reset: flush with in_valid=1 and out_valid=1 -> next cycle out_valid=0, input not captured; rst mid-stall -> out_valid=0, all ex_*=0.
- Illegal: opcode=000010 -> ex_illegal=1, aluop=0000, wr_en=0. R add with rd=0 -> wr_en=0.
- Forwarding (EX_ISSUE_FORWARDING_EN defined):
  - rs_idx=3, fwd1={1,3,0xAA}, fwd2={1,3,0xBB} -> ex_a=0xAA.
  - rs_idx=0 with matching fwd -> ex_a=rs_val.
  - Without the macro -> ex_a=rs_val.
